// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID slot and 1-entry skid buffer
//
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_curr_PC / o_next_PC        PC register loop; o_next_PC is combinational
//   o_imem_req, o_imem_addr      instruction memory request, address stable until ack
//   i_imem_ack, i_imem_rdata     memory completion and instruction word
//   i_redirect, i_redirect_PC    branch/jump pulse and target
//   o_id_valid, o_id_instr,
//   o_id_PC, o_id_PC_plus4       IF/ID slot contents
//   i_id_ready                   decode accepts the slot this cycle
module fetch_unit #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_curr_PC,
  output logic [XLEN-1:0] o_next_PC,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_PC,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_PC,
  output logic [XLEN-1:0] o_id_PC_plus4,
  input  logic            i_id_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [1:0]      state;
  logic [XLEN-1:0] addr_q;

  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  logic issue;
  logic ack;
  logic complete;
  logic consume;

  // Target low bits are forced to zero, so they never reach any logic.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^i_redirect_PC[1:0];

  always_comb begin
    issue       = i_rst_n && (state == IDLE) && !skid_valid && !i_redirect;
    o_imem_req  = i_rst_n && (issue || (state != IDLE));
    o_imem_addr = (state == IDLE) ? i_curr_PC : addr_q;
    // An ack only means something while a request is on the bus.
    ack         = i_imem_ack && o_imem_req;
    complete    = ack && (state != DROP) && !i_redirect;
    consume     = o_id_valid && i_id_ready;

    if (!i_rst_n) begin
      o_next_PC = '0;
    end else if (i_redirect) begin
      o_next_PC = {i_redirect_PC[XLEN-1:2], 2'b00};
    end else if (issue) begin
      o_next_PC = i_curr_PC + STEP;
    end else begin
      o_next_PC = i_curr_PC;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      o_id_valid    <= 1'b0;
      o_id_instr    <= '0;
      o_id_PC       <= '0;
      o_id_PC_plus4 <= '0;
      skid_valid    <= 1'b0;
      skid_instr    <= '0;
      skid_pc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            addr_q <= i_curr_PC;
            if (!i_imem_ack) state <= WAIT;
          end
        end
        WAIT: begin
          if (i_imem_ack)      state <= IDLE;
          else if (i_redirect) state <= DROP;
        end
        DROP: begin
          if (i_imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (i_redirect) begin
        o_id_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (complete) begin
        if (!o_id_valid || (consume && !skid_valid)) begin
          o_id_valid    <= 1'b1;
          o_id_instr    <= i_imem_rdata;
          o_id_PC       <= o_imem_addr;
          o_id_PC_plus4 <= o_imem_addr + STEP;
        end else if (consume) begin
          // Skid advances to the slot and the new word takes the skid,
          // keeping program order.
          o_id_instr    <= skid_instr;
          o_id_PC       <= skid_pc;
          o_id_PC_plus4 <= skid_pc + STEP;
          skid_instr    <= i_imem_rdata;
          skid_pc       <= o_imem_addr;
        end else begin
          skid_valid <= 1'b1;
          skid_instr <= i_imem_rdata;
          skid_pc    <= o_imem_addr;
        end
      end else if (consume) begin
        if (skid_valid) begin
          o_id_instr    <= skid_instr;
          o_id_PC       <= skid_pc;
          o_id_PC_plus4 <= skid_pc + STEP;
          skid_valid    <= 1'b0;
        end else begin
          o_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule
